// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with prescaler, clear, load,
// registered terminal-count pulse and sticky wrap flag.
module counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PS_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    psc;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;

    // Wrap is detected by comparison, so MODULUS = 2^WIDTH never overflows.
    always_comb begin
        step         = en && (psc == PS_MAX);
        wrap         = 1'b0;
        next_count   = count;
        load_clamped = (load_val > MAX) ? MAX : load_val;
        if (step) begin
            if (up) begin
                wrap       = (count == MAX);
                next_count = wrap ? '0 : count + WIDTH'(1);
            end else begin
                wrap       = (count == '0);
                next_count = wrap ? MAX : count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            psc   <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            psc   <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            psc   <= '0;
            tc    <= 1'b0;
            if (ovf_clr)
                ovf <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= wrap;
            if (en)
                psc <= step ? '0 : psc + PW'(1);
            // A wrap on the same edge as ovf_clr keeps the flag set.
            if (wrap)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter, successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, a clock-enable prescaler, direction control, synchronous clear, parallel load, a registered terminal-count pulse and a sticky wrap flag. It is the pipeline's general-purpose cycle/event counter for timers, stall watchdogs and performance counters, with a single clock domain.

## Interface

**Parameters**
- `WIDTH`, 4: count register width in bits (≥ 1).
- `MODULUS`, 10: count range is 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- `PRESCALE`, 1: number of enabled cycles per count step. Legal range ≥ 1; 1 means a step on every enabled cycle.

**Ports**
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronised externally.
- `en`, in, 1: count enable. Gates the prescaler.
- `up`, in, 1: direction. 1 = increment, 0 = decrement.
- `clr`, in, 1: synchronous clear.
- `load`, in, 1: synchronous parallel load.
- `load_val`, in, WIDTH: value for `load`.
- `ovf_clr`, in, 1: synchronous clear of `ovf`.
- `count`, out, WIDTH: current count (registered).
- `tc`, out, 1: one-cycle terminal-count pulse (registered).
- `ovf`, out, 1: sticky wrap flag (registered).

## Operation

- **Reset values:** `count` = 0, `tc` = 0, `ovf` = 0, prescaler = 0.
- **Priority per edge:** `clr` > `load` > step. The inputs `up` and `en` are ignored while `clr` or `load` is high.
- **`clr`:**
  - `count` ← 0, prescaler ← 0, `tc` ← 0, `ovf` ← 0.
- **`load`:**
  - `count` ← `load_val`, or MODULUS-1 if `load_val` ≥ MODULUS (clamped).
  - prescaler ← 0, `tc` ← 0, `ovf` unchanged.
- **Prescaler:**
  - Internal counter of width clog2(PRESCALE) (minimum 1 bit), range 0..PRESCALE-1.
  - Advances only when `en` = 1; holds otherwise.
  - Issues a step when `en` = 1 and prescaler = PRESCALE-1, then returns to 0.
  - With PRESCALE = 1, every enabled cycle is a step.
- **Step, up = 1:**
  - count = MODULUS-1 → 0, and it is a wrap.
  - Otherwise count + 1.
- **Step, up = 0:**
  - count = 0 → MODULUS-1, and it is a wrap.
  - Otherwise count − 1.
- **`tc`:** set to 1 on the edge where a wrap step occurs. Set to 0 on every other edge, so it is never high for two consecutive cycles unless wraps occur on consecutive steps.
- **`ovf`:**
  - Set on any wrap step.
  - Cleared by `ovf_clr` or `clr`.
  - If a wrap and `ovf_clr` occur on the same edge, set wins.
- **Arithmetic:** modulo MODULUS only, with no intermediate overflow of WIDTH. When MODULUS = 2^WIDTH, behaviour equals natural binary wrap.
- **Direction change mid-count:** takes effect on the next step. The prescaler phase is not reset.

## Timing

- All outputs are registered. A step at edge N is visible on `count` and `tc` after edge N; there is no combinational path from input to output.
- Latency from `en` rising to the first `count` change is PRESCALE edges, provided prescaler = 0.
- `tc` is coincident with `count` showing its post-wrap value (0 when up, MODULUS-1 when down).
- `reset` assertion mid-operation forces all outputs to their reset values asynchronously, independent of `clk`. Counting resumes from 0 on the first enabled edge after release.

## Test plan

- **Up count with wrap.** WIDTH=4, MODULUS=10, PRESCALE=1; release reset, hold `en`=1, `up`=1 for 12 cycles.
  - `count` goes 1..9, 0, 1, 2.
  - `tc` = 1 only in the cycle showing `count`=0.
  - `ovf` = 1 from that cycle on.
- **Down count with wrap.** From `count`=1, set `up`=0 for 3 steps.
  - `count` goes 0, 9, 8.
  - `tc` pulses only with `count`=9.
- **Prescaler and enable.** PRESCALE=3, `en`=1.
  - `count` increments on every 3rd edge: 0→1 after edge 3, 1→2 after edge 6.
  - Dropping `en` for 5 cycles at prescaler=1 freezes both `count` and the prescaler. Resuming needs 2 more enabled edges for the next step.
- **Load priority and clamp.**
  - `load_val`=15 with `load`=1 → `count`=9.
  - Same edge as `clr`=1 → `count`=0, `ovf`=0.
  - `load`=1 together with a wrap-eligible `en` → no step, `tc`=0.
- **`ovf` handling.** With `ovf`=1:
  - `ovf_clr` → `ovf`=0 next cycle.
  - `ovf_clr` on the same edge as a wrap → `ovf` stays 1.
- **Async reset mid-count.**
  - At `count`=7, assert `reset`=0 between edges → `count`, `tc`, `ovf` = 0 immediately, before the next edge.
  - After release, the first enabled step gives `count`=1.
